// File: rtl/serv_mdu_pkg.sv
// Shared definitions for the serial RV32M multiply/divide unit: funct3 codes,
// FSM states and operand signedness helpers.
package serv_mdu_pkg;

    localparam logic [2:0] MDU_MUL    = 3'd0;
    localparam logic [2:0] MDU_MULH   = 3'd1;
    localparam logic [2:0] MDU_MULHSU = 3'd2;
    localparam logic [2:0] MDU_MULHU  = 3'd3;
    localparam logic [2:0] MDU_DIV    = 3'd4;
    localparam logic [2:0] MDU_DIVU   = 3'd5;
    localparam logic [2:0] MDU_REM    = 3'd6;
    localparam logic [2:0] MDU_REMU   = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } mdu_state_e;

    function automatic logic is_signed_a(input logic [2:0] f);
        return (f != MDU_MULHU) && (f != MDU_DIVU) && (f != MDU_REMU);
    endfunction

    function automatic logic is_signed_b(input logic [2:0] f);
        return (f == MDU_MUL) || (f == MDU_MULH) || (f == MDU_DIV) || (f == MDU_REM);
    endfunction

endpackage

// File: rtl/serv_ext_mdu_if.sv
// Request/response bundle between the core's extension slot and the MDU.
interface serv_ext_mdu_if #(
    parameter int XLEN = 32
);
    logic            i_valid;
    logic [2:0]      i_funct3;
    logic [XLEN-1:0] i_rs1;
    logic [XLEN-1:0] i_rs2;
    logic            o_busy;
    logic            o_ready;
    logic [XLEN-1:0] o_rd;

    modport master (
        output i_valid, i_funct3, i_rs1, i_rs2,
        input  o_busy, o_ready, o_rd
    );

    modport slave (
        input  i_valid, i_funct3, i_rs1, i_rs2,
        output o_busy, o_ready, o_rd
    );
endinterface

// File: rtl/serv_mdu_divstep.sv
// One restoring division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module serv_mdu_divstep #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_rem,
    input  logic [XLEN-1:0] i_divisor,
    input  logic            i_bit,
    output logic [XLEN-1:0] o_rem,
    output logic            o_qbit
);
    logic [XLEN:0] w_trial;
    logic [XLEN:0] w_diff;

    // i_rem < i_divisor always holds, so a clear top bit of the difference means "fits"
    assign w_trial = {i_rem, i_bit};
    assign w_diff  = w_trial - {1'b0, i_divisor};
    assign o_qbit  = ~w_diff[XLEN];
    assign o_rem   = o_qbit ? w_diff[XLEN-1:0] : w_trial[XLEN-1:0];
endmodule

// File: rtl/serv_ext_mdu.sv
// Iterative RV32M multiply/divide unit for the SERV extension slot.
// Divider datapath is present only when SERV_MDU_DIV_EN is defined.
module serv_ext_mdu
    import serv_mdu_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int MUL_STEP = 1
) (
    input logic           clk,
    input logic           i_rst_n,
    serv_ext_mdu_if.slave bus
);
    localparam int             CW      = $clog2(XLEN) + 1;
    localparam logic [CW-1:0]  MUL_CYC = CW'(XLEN / MUL_STEP);
    localparam logic [CW-1:0]  DIV_CYC = CW'(XLEN);
    localparam logic [XLEN-1:0] XMIN   = {1'b1, {(XLEN-1){1'b0}}};

    // state | meaning
    // IDLE  | waiting for i_valid
    // MUL   | shift-add, MUL_STEP multiplier bits per cycle
    // DIV   | restoring divide, one quotient bit per cycle
    // DONE  | sign fix-up, o_rd valid, o_ready pulse
    mdu_state_e r_state, w_next;

    logic [CW-1:0]     r_cnt;
    logic [2:0]        r_funct3;
    logic              r_sa, r_sb, r_special;
    logic [2*XLEN-1:0] r_a;
    logic [XLEN-1:0]   r_b;
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_rd;

    logic              w_sa, w_sb, w_is_div, w_special;
    logic [XLEN-1:0]   w_mag_a, w_mag_b, w_spec_rd, w_result;
    logic [2*XLEN-1:0] w_pp, w_prod;

    assign w_sa     = is_signed_a(bus.i_funct3) & bus.i_rs1[XLEN-1];
    assign w_sb     = is_signed_b(bus.i_funct3) & bus.i_rs2[XLEN-1];
    assign w_mag_a  = w_sa ? -bus.i_rs1 : bus.i_rs1;
    assign w_mag_b  = w_sb ? -bus.i_rs2 : bus.i_rs2;
    assign w_is_div = bus.i_funct3[2];

`ifdef SERV_MDU_DIV_EN
    logic            w_div0, w_ovf, w_qbit;
    logic [XLEN-1:0] w_rem_nx;

    assign w_div0    = (bus.i_rs2 == '0);
    assign w_ovf     = ((bus.i_funct3 == MDU_DIV) || (bus.i_funct3 == MDU_REM))
                       && (bus.i_rs1 == XMIN) && (bus.i_rs2 == '1);
    assign w_special = w_is_div & (w_div0 | w_ovf);
    // funct3[1] separates REM* from DIV*
    assign w_spec_rd = w_div0 ? (bus.i_funct3[1] ? bus.i_rs1 : '1)
                              : (bus.i_funct3[1] ? '0 : XMIN);

    serv_mdu_divstep #(.XLEN(XLEN)) u_divstep (
        .i_rem     (r_acc[XLEN-1:0]),
        .i_divisor (r_a[XLEN-1:0]),
        .i_bit     (r_b[XLEN-1]),
        .o_rem     (w_rem_nx),
        .o_qbit    (w_qbit)
    );
`else
    assign w_special = w_is_div;
    assign w_spec_rd = '0;
`endif

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (bus.i_valid) w_next = w_special ? DONE : (w_is_div ? DIV : MUL);
            MUL,
            DIV:  if (r_cnt == CW'(1)) w_next = DONE;
            DONE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_pp = '0;
        for (int j = 0; j < MUL_STEP; j++)
            if (r_b[j]) w_pp = w_pp + (r_a << j);
    end

    always_comb begin
        w_prod   = (r_sa ^ r_sb) ? -r_acc : r_acc;
        w_result = '0;
        if (r_special)                 w_result = r_acc[XLEN-1:0];
        else if (r_funct3 == MDU_MUL)  w_result = w_prod[XLEN-1:0];
        else if (!r_funct3[2])         w_result = w_prod[2*XLEN-1:XLEN];
`ifdef SERV_MDU_DIV_EN
        else if (r_funct3[1])          w_result = r_sa ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
        else                           w_result = (r_sa ^ r_sb) ? -r_b : r_b;
`endif
    end

    // For division r_a holds the divisor, r_b shifts the dividend out and the quotient in,
    // and r_acc's low half is the partial remainder.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt     <= '0;
            r_funct3  <= '0;
            r_sa      <= 1'b0;
            r_sb      <= 1'b0;
            r_special <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_acc     <= '0;
            r_rd      <= '0;
        end else begin
            case (r_state)
                IDLE: if (bus.i_valid) begin
                    r_funct3  <= bus.i_funct3;
                    r_sa      <= w_sa;
                    r_sb      <= w_sb;
                    r_special <= w_special;
                    r_acc     <= {{XLEN{1'b0}}, w_spec_rd};
                    r_cnt     <= w_is_div ? DIV_CYC : MUL_CYC;
                    r_a       <= {{XLEN{1'b0}}, (w_is_div ? w_mag_b : w_mag_a)};
                    r_b       <= w_is_div ? w_mag_a : w_mag_b;
                end
                MUL: begin
                    r_acc <= r_acc + w_pp;
                    r_a   <= r_a << MUL_STEP;
                    r_b   <= r_b >> MUL_STEP;
                    r_cnt <= r_cnt - CW'(1);
                end
`ifdef SERV_MDU_DIV_EN
                DIV: begin
                    r_acc[XLEN-1:0] <= w_rem_nx;
                    r_b             <= {r_b[XLEN-2:0], w_qbit};
                    r_cnt           <= r_cnt - CW'(1);
                end
`endif
                DONE: r_rd <= w_result;
                default: ;
            endcase
        end
    end

    assign bus.o_busy  = (r_state != IDLE);
    assign bus.o_ready = (r_state == DONE);
    assign bus.o_rd    = (r_state == DONE) ? w_result : r_rd;
endmodule

// File: tb/tb_serv_ext_mdu.sv
// Bench for serv_ext_mdu: directed vectors with literal results plus a
// cycle-by-cycle comparison against an arithmetic reference model.
module tb_serv_ext_mdu;
    localparam int XLEN = 32;
    parameter  int MUL_STEP = 1;
`ifdef SERV_MDU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif
    localparam logic [31:0] XMIN = 32'h8000_0000;
    localparam int LM = XLEN / MUL_STEP + 1;
    localparam int LD = DIV_EN ? XLEN + 1 : 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serv_ext_mdu_if #(.XLEN(XLEN)) bus ();
    serv_ext_mdu #(.XLEN(XLEN), .MUL_STEP(MUL_STEP)) dut (
        .clk     (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_rd(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] sa, za, sb, zb, p;
        logic [31:0] r;
        sa = {{32{a[31]}}, a};
        za = {32'b0, a};
        sb = {{32{b[31]}}, b};
        zb = {32'b0, b};
        p  = '0;
        r  = '0;
        case (f)
            3'd0: begin p = sa * sb; r = p[31:0];  end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * zb; r = p[63:32]; end
            3'd3: begin p = za * zb; r = p[63:32]; end
            3'd4: if (b == 0) r = '1;
                  else if (a == XMIN && b == '1) r = XMIN;
                  else r = $signed(a) / $signed(b);
            3'd5: r = (b == 0) ? '1 : a / b;
            3'd6: if (b == 0) r = a;
                  else if (a == XMIN && b == '1) r = '0;
                  else r = $signed(a) % $signed(b);
            default: r = (b == 0) ? a : a % b;
        endcase
        if (f[2] && !DIV_EN) r = '0;
        return r;
    endfunction

    function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (!f[2]) return XLEN / MUL_STEP + 1;
        if (!DIV_EN || b == 0) return 1;
        if ((f == 3'd4 || f == 3'd6) && a == XMIN && b == '1) return 1;
        return XLEN + 1;
    endfunction

    // Model: edge count, whether an op is outstanding, edge that opens its ready cycle
    int          e = 0;
    logic        m_active = 1'b0;
    int          m_done = 0;
    logic [31:0] m_exp = '0;
    logic [31:0] m_held = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 1'b0;
            m_held   = '0;
        end else begin
            e++;
            if (!m_active) begin
                if (bus.i_valid) begin
                    m_active = 1'b1;
                    m_done   = e + ref_lat(bus.i_funct3, bus.i_rs1, bus.i_rs2) - 1;
                    m_exp    = ref_rd(bus.i_funct3, bus.i_rs1, bus.i_rs2);
                end
            end else if (e == m_done + 1) begin
                m_active = 1'b0;
                m_held   = m_exp;
            end
        end
    end

    always @(negedge clk) begin
        logic exp_rdy;
        if (rst_n) begin
            exp_rdy = m_active && (e == m_done);
            chk("cyc_busy",  {31'b0, bus.o_busy},  {31'b0, m_active});
            chk("cyc_ready", {31'b0, bus.o_ready}, {31'b0, exp_rdy});
            chk("cyc_rd",    bus.o_rd, exp_rdy ? m_exp : m_held);
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (m_active && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (m_active) begin
            n_fail++;
            $display("FAIL idle_timeout: busy after %0d cycles", n);
        end
    endtask

    task automatic run_op(input string nm, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_rd, input int exp_lat);
        int n;
        wait_idle();
        bus.i_valid  = 1'b1;
        bus.i_funct3 = f;
        bus.i_rs1    = a;
        bus.i_rs2    = b;
        @(negedge clk);
        bus.i_valid = 1'b0;
        n = 1;
        while (!bus.o_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.o_ready) begin
            n_fail++;
            $display("FAIL %s ready_timeout: no o_ready within %0d cycles", nm, n);
        end else begin
            chk({nm, " rd"}, bus.o_rd, exp_rd);
            chk({nm, " lat"}, n, exp_lat);
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return XMIN;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_valid  = 1'b0;
        bus.i_funct3 = '0;
        bus.i_rs1    = '0;
        bus.i_rs2    = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy",  {31'b0, bus.o_busy},  32'd0);
        chk("rst_ready", {31'b0, bus.o_ready}, 32'd0);
        chk("rst_rd",    bus.o_rd, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("mul_7_m3",   3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, LM);
        run_op("mul_minmin", 3'd0, XMIN, XMIN, 32'h0, LM);
        run_op("mulh_min",   3'd1, XMIN, XMIN, 32'h4000_0000, LM);
        run_op("mulhsu_min", 3'd2, XMIN, XMIN, 32'hC000_0000, LM);
        run_op("mulhu_min",  3'd3, XMIN, XMIN, 32'h4000_0000, LM);
        run_op("div_m7_2",   3'd4, 32'hFFFF_FFF9, 32'd2, DIV_EN ? 32'hFFFF_FFFD : 32'h0, LD);
        run_op("rem_m7_2",   3'd6, 32'hFFFF_FFF9, 32'd2, DIV_EN ? 32'hFFFF_FFFF : 32'h0, LD);
        run_op("divu_100_7", 3'd5, 32'd100, 32'd7, DIV_EN ? 32'd14 : 32'h0, LD);
        run_op("remu_100_7", 3'd7, 32'd100, 32'd7, DIV_EN ? 32'd2 : 32'h0, LD);
        run_op("div_5_0",    3'd4, 32'd5, 32'd0, DIV_EN ? 32'hFFFF_FFFF : 32'h0, 1);
        run_op("rem_5_0",    3'd6, 32'd5, 32'd0, DIV_EN ? 32'd5 : 32'h0, 1);
        run_op("div_ovf",    3'd4, XMIN, 32'hFFFF_FFFF, DIV_EN ? XMIN : 32'h0, 1);
        run_op("rem_ovf",    3'd6, XMIN, 32'hFFFF_FFFF, 32'h0, 1);
        run_op("divu_ovf",   3'd5, XMIN, 32'hFFFF_FFFF, 32'h0, LD);

        // Abort a divide mid-flight with an asynchronous reset
        wait_idle();
        bus.i_valid  = 1'b1;
        bus.i_funct3 = 3'd4;
        bus.i_rs1    = 32'hFFFF_FFF9;
        bus.i_rs2    = 32'd2;
        @(negedge clk);
        bus.i_valid = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy",  {31'b0, bus.o_busy},  32'd0);
        chk("abort_ready", {31'b0, bus.o_ready}, 32'd0);
        chk("abort_rd",    bus.o_rd, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        run_op("mul_3_4", 3'd0, 32'd3, 32'd4, 32'd12, LM);

        // Requests held continuously; the per-cycle compare checks every accepted op
        wait_idle();
        bus.i_valid = 1'b1;
        for (int i = 0; i < 20000; i++) begin
            bus.i_funct3 = 3'($urandom_range(0, 7));
            bus.i_rs1    = pick();
            bus.i_rs2    = pick();
            @(negedge clk);
        end
        bus.i_valid = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
